sr8_seq_ctrl: RTL and testbench
===============================

Name: sr8_seq_ctrl

Overview:
- Sequencer for one 8-entry complex shift register in a 64-point FFT datapath (10-bit re/im per entry).
- Accepts samples from upstream with a valid/ready handshake and drives the register's write enable to load one group of 8.
- Then steps the register's 3-bit read select 0..7 toward downstream with a valid/ready handshake.
- Counts 8 groups per 64-point frame and flags frame boundaries.

Parameters:
- DEPTH, 8, entries per group. Fixed at 8 because sel is 3 bits.
- GROUPS, 8, groups per frame (64 points total).
- GW, 3, width of the group index.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active low
- enable  in  1  leave IDLE and start accepting samples
- flush  in  1  synchronous abort to IDLE; counters cleared
- in_valid  in  1  upstream sample present (data goes straight to the register)
- in_ready  out  1  controller can accept a sample
- ren  out  1  register write enable
- sel  out  3  register read select
- out_valid  out  1  register output at sel is valid for downstream
- out_ready  in  1  downstream accepts the current sample
- out_last  out  1  current output is the last of its group (sel==7)
- frame_last  out  1  out_last in the last group of the frame
- frame_done  out  1  one-cycle pulse after the 64th sample is output
- group_idx  out  GW  index of the group being loaded or drained
- busy  out  1  state is not IDLE

Behaviour:
- Register convention: with ren high, the register captures one sample per clock. After 8 captures, sel=k reads the k-th captured sample of that group, with sel=0 selecting the first. The register output follows sel combinationally.
- States are IDLE, LOAD and DRAIN.
- Reset (rst_n low at an edge):
  - state goes to IDLE.
  - load count, sel and group_idx go to 0.
  - in_ready, ren, out_valid, out_last, frame_last, frame_done and busy are 0.
  - Reset takes precedence over every other input, including mid-group.
- IDLE:
  - in_ready=0, out_valid=0.
  - enable=1 moves to LOAD on the next edge.
- LOAD:
  - in_ready=1.
  - ren = in_valid & in_ready. This is combinational, so the capture happens on the same edge as the handshake.
  - Each accept increments the load count.
  - On the 8th accept the state moves to DRAIN, sel=0 and out_valid=1 from the next cycle. There is no bubble.
  - in_valid low holds the load count; gaps are allowed.
- DRAIN:
  - in_ready=0 and ren=0, so the register contents are frozen.
  - out_valid=1.
  - On out_valid & out_ready with sel<7: sel increments on the next edge.
  - With out_ready low, sel holds and out_valid stays 1.
  - On an accept with sel==7:
    - sel returns to 0 and the load count clears.
    - group_idx increments, wrapping 7 to 0.
    - The state returns to LOAD. It goes to LOAD even if enable has dropped; enable is sampled only in IDLE.
- out_last = DRAIN & sel==7. frame_last = out_last & group_idx==7. Both are combinational from registered state.
- frame_done: registered pulse high for exactly one cycle following the accept where frame_last=1.
- flush=1 at any edge in any state (with rst_n high):
  - Gives the same values as reset, except enable may start a new frame on the following edge.
  - A handshake in the same cycle as flush is discarded and does not advance any counter.
- Counters wrap modulo 8; there is no saturation and no error output.
- Throughput: 64 input cycles + 64 output cycles per frame at full rate.

Test Plan:
- Reset then enable: drive rst_n=0 for 2 clocks, then 1, with enable=1.
  - Expect all outputs 0 during reset.
  - Next cycle busy=1, in_ready=1.
- Full-rate group: in_valid=1 with din 0..7 on consecutive cycles, out_ready=1.
  - Expect ren high for 8 cycles.
  - Then out_valid for 8 cycles with sel 0..7 and register output 0..7.
  - Expect out_last on the 8th output cycle, then LOAD again with group_idx=1.
- Backpressure: during DRAIN hold out_ready=0 for 3 cycles at sel=4.
  - Expect sel to stay 4 and out_valid to stay 1.
  - After release, sel advances to 5; no sample is lost or repeated.
- Input gaps: in_valid pattern 1,0,1,1,0,1,1,1,1,1.
  - Expect ren to mirror in_valid while in LOAD.
  - DRAIN begins only after the 8th accept.
- Full frame: stream 64 samples with both sides continuous.
  - Expect frame_last during the 64th output and a single frame_done pulse one cycle later.
  - group_idx wraps to 0.
- Flush/reset mid-operation: assert flush at load count 5 in group 2; in another run, pull rst_n low during DRAIN at sel=3.
  - In both cases expect IDLE next cycle with sel=0, group_idx=0 and no frame_done.

Source files
------------

// File: rtl/sr8_seq_ctrl.sv
// Sequencer for one 8-entry complex shift register: loads a group of 8, then drains it by stepping sel 0..7.
// Latency: drain begins the cycle after the 8th accept; backpressure: out_ready low holds sel, input is closed while draining.
module sr8_seq_ctrl #(
    parameter int DEPTH  = 8,
    parameter int GROUPS = 8,
    parameter int GW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ren,
    output logic [2:0]    sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          frame_last,
    output logic          frame_done,
    output logic [GW-1:0] group_idx,
    output logic          busy
);

    localparam logic [2:0]    LAST_IDX = 3'(DEPTH - 1);
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] load_cnt;
    logic       in_accept;
    logic       out_accept;

    // The capture happens on the handshake edge itself, so ren is not registered.
    assign ren        = in_valid & in_ready;
    assign in_accept  = ren;
    assign out_accept = out_valid & out_ready;

    assign out_last   = (state == DRAIN) && (sel == LAST_IDX);
    assign frame_last = out_last && (group_idx == LAST_GRP);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state      <= IDLE;
            load_cnt   <= '0;
            sel        <= '0;
            group_idx  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_accept) begin
                        load_cnt <= load_cnt + 3'd1;
                        if (load_cnt == LAST_IDX) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            sel       <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_accept) begin
                        if (sel == LAST_IDX) begin
                            // enable is ignored here: a started frame keeps cycling groups
                            state      <= LOAD;
                            sel        <= '0;
                            load_cnt   <= '0;
                            group_idx  <= group_idx + 1'b1;
                            in_ready   <= 1'b1;
                            out_valid  <= 1'b0;
                            frame_done <= (group_idx == LAST_GRP);
                        end else begin
                            sel <= sel + 3'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr8_seq_ctrl.sv
// Directed bench for sr8_seq_ctrl with a behavioural 8-entry shift register driven by ren/sel.
module tb_sr8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, enable, flush, in_valid, out_ready;
    logic       in_ready, ren, out_valid, out_last, frame_last, frame_done, busy;
    logic [2:0] sel, group_idx;
    logic [9:0] din;
    logic [9:0] sr [8];
    logic [9:0] reg_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sr8_seq_ctrl #(.DEPTH(8), .GROUPS(8), .GW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ren        (ren),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_last (frame_last),
        .frame_done (frame_done),
        .group_idx  (group_idx),
        .busy       (busy)
    );

    // Shift register: newest sample enters at the top, so sr[0] is the oldest of the last 8.
    always @(posedge clk) begin
        if (ren) begin
            for (int i = 0; i < 7; i++) sr[i] <= sr[i+1];
            sr[7] <= din;
        end
    end
    assign reg_out = sr[sel];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_group(input int base);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 10'(base + i);
            #1;
            check_eq("lg_ren", 32'(ren), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_n(input int n, input int base);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            check_eq("dr_sel", 32'(sel), 32'(k));
            check_eq("dr_dat", 32'(reg_out), 32'(base + k));
            tick();
        end
    endtask

    initial begin
        int pat [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        int cnt;
        int k;
        int stall;

        rst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; din = '0;

        // Reset, then leave IDLE on the first edge with rst_n high
        tick(); tick();
        check_eq("rst_outs", 32'({in_ready, ren, out_valid, out_last, frame_last, frame_done, busy}), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_grp", 32'(group_idx), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("en_busy", 32'(busy), 32'd1);
        check_eq("en_in_ready", 32'(in_ready), 32'd1);
        check_eq("en_out_valid", 32'(out_valid), 32'd0);

        // Full-rate group 0, in_valid kept high into DRAIN to prove ren is closed
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 10'(i);
            #1;
            check_eq("g0_ren", 32'(ren), 32'd1);
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            #1;
            check_eq("g0_out_valid", 32'(out_valid), 32'd1);
            check_eq("g0_sel", 32'(sel), 32'(j));
            check_eq("g0_dat", 32'(reg_out), 32'(j));
            check_eq("g0_last", 32'(out_last), 32'(j == 7));
            check_eq("g0_ren_drain", 32'(ren), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check_eq("g0_back_load", 32'(in_ready), 32'd1);
        check_eq("g0_grp", 32'(group_idx), 32'd1);
        check_eq("g0_ov_off", 32'(out_valid), 32'd0);

        // Group 1 with input gaps
        cnt = 0;
        for (int p = 0; p < 10; p++) begin
            in_valid = pat[p][0];
            din = 10'(100 + cnt);
            #1;
            check_eq("gap_ren", 32'(ren), 32'(pat[p]));
            check_eq("gap_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (pat[p] == 1) cnt++;
        end
        in_valid = 1'b0;
        #1;
        check_eq("gap_drain", 32'(out_valid), 32'd1);

        // Drain group 1 with a 3-cycle stall at sel=4
        k = 0; stall = 0;
        while (k < 8) begin
            out_ready = (k == 4 && stall < 3) ? 1'b0 : 1'b1;
            #1;
            check_eq("bp_sel", 32'(sel), 32'(k));
            check_eq("bp_ov", 32'(out_valid), 32'd1);
            check_eq("bp_dat", 32'(reg_out), 32'(100 + k));
            tick();
            if (out_ready) k++;
            else stall++;
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_grp", 32'(group_idx), 32'd2);

        // Flush at load count 5 of group 2; the handshake on the flush edge is dropped
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 10'(200 + i);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check_eq("fl_busy", 32'(busy), 32'd0);
        check_eq("fl_in_ready", 32'(in_ready), 32'd0);
        check_eq("fl_ren", 32'(ren), 32'd0);
        check_eq("fl_sel", 32'(sel), 32'd0);
        check_eq("fl_grp", 32'(group_idx), 32'd0);
        check_eq("fl_fdone", 32'(frame_done), 32'd0);
        tick();
        check_eq("fl_restart", 32'(in_ready), 32'd1);

        // Full 64-point frame, both sides continuous; enable dropped mid-frame
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            if (g == 3) enable = 1'b0;
            #1;
            check_eq("fr_grp", 32'(group_idx), 32'(g));
            for (int i = 0; i < 8; i++) begin
                din = 10'(g * 8 + i);
                #1;
                check_eq("fr_ren", 32'(ren), 32'd1);
                tick();
            end
            for (int j = 0; j < 8; j++) begin
                #1;
                check_eq("fr_sel", 32'(sel), 32'(j));
                check_eq("fr_dat", 32'(reg_out), 32'(g * 8 + j));
                check_eq("fr_flast", 32'(frame_last), 32'(g == 7 && j == 7));
                check_eq("fr_fdone_low", 32'(frame_done), 32'd0);
                tick();
            end
        end
        check_eq("fr_fdone", 32'(frame_done), 32'd1);
        check_eq("fr_grp_wrap", 32'(group_idx), 32'd0);
        check_eq("fr_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        tick();
        check_eq("fr_fdone_pulse", 32'(frame_done), 32'd0);

        // Reset during DRAIN at sel=3 of group 1
        flush = 1'b1;
        tick();
        flush = 1'b0;
        enable = 1'b1;
        tick();
        load_group(300);
        drain_n(8, 300);
        load_group(400);
        drain_n(3, 400);
        #1;
        check_eq("rs_pre_sel", 32'(sel), 32'd3);
        check_eq("rs_pre_grp", 32'(group_idx), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("rs_busy", 32'(busy), 32'd0);
        check_eq("rs_ov", 32'(out_valid), 32'd0);
        check_eq("rs_sel", 32'(sel), 32'd0);
        check_eq("rs_grp", 32'(group_idx), 32'd0);
        check_eq("rs_fdone", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
